// File: rtl/bj_timer_pkg.sv
// bj_timer_pkg: shared types and elaboration helpers for the BlackJack
// event counter / timeout timer (bj_timer_counter and bj_tick_gen).
package bj_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_t;

  // Clock cycles per timer tick; returns 0 for a zero tick rate so that the
  // parameter check can still report the problem instead of dividing by zero.
  function automatic int calc_div(input int clk_hz, input int tick_hz);
    if (tick_hz <= 0) return 0;
    return clk_hz / tick_hz;
  endfunction

  // Prescaler register width; never narrower than one bit.
  function automatic int presc_width(input int div);
    if (div <= 2) return 1;
    return $clog2(div);
  endfunction

  // Elapsed-tick register width, wide enough to hold TIMEOUT_TICKS.
  function automatic int elapsed_width(input int ticks);
    if (ticks <= 1) return 1;
    return $clog2(ticks + 1);
  endfunction

  // True when the clock/tick ratio is an exact integer of at least 2 and the
  // timeout is at least one tick long.
  function automatic bit params_ok(input int clk_hz, input int tick_hz, input int ticks);
    if (tick_hz <= 0) return 1'b0;
    if ((clk_hz % tick_hz) != 0) return 1'b0;
    if ((clk_hz / tick_hz) < 2) return 1'b0;
    if (ticks < 1) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/bj_timer_counter_tick_gen.sv
// bj_tick_gen: free-running prescaler producing a one-cycle tick strobe every
// DIV cycles. 'restart' zeroes the prescaler; with BJ_TIMER_PAUSE_EN defined,
// 'hold' freezes it and suppresses the strobe.
// 'wrap' is the combinational "prescaler is at DIV-1 and advancing" condition,
// i.e. the edge at which 'tick' gets set.
module bj_tick_gen
  import bj_timer_pkg::*;
#(
  parameter int DIV = 25000
) (
  input  logic clk_50M,
  input  logic i_Reset,
  input  logic restart,
`ifdef BJ_TIMER_PAUSE_EN
  input  logic hold,
`endif
  output logic tick,
  output logic wrap
);

  localparam int PW = presc_width(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] count;
  logic          active;

`ifdef BJ_TIMER_PAUSE_EN
  assign active = !hold;
`else
  assign active = 1'b1;
`endif

  assign wrap = active && (count == LAST);

  // Prescaler counts 0..DIV-1, restarts on request, and registers the strobe.
  always_ff @(posedge clk_50M) begin
    if (i_Reset) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      tick <= wrap;
      if (restart) begin
        count <= '0;
      end else if (wrap) begin
        count <= '0;
      end else if (active) begin
        count <= count + PW'(1);
      end
    end
  end

endmodule

// File: rtl/bj_timer_counter.sv
// bj_timer_counter: saturating event counter plus one-shot timeout timer for
// the BlackJack datapath, all in the clk_50M domain.
// Define BJ_TIMER_PAUSE_EN to add the i_Pause input that freezes a running timer.
module bj_timer_counter
  import bj_timer_pkg::*;
#(
  parameter int WIDTH         = 12,
  parameter int CLK_HZ        = 50000000,
  parameter int TICK_HZ       = 2000,
  parameter int TIMEOUT_TICKS = 4000
) (
  input  logic             clk_50M,
  input  logic             i_Reset,
  input  logic             i_Clear,
  input  logic             i_Inc,
  input  logic             i_Start,
  input  logic             i_Abort,
`ifdef BJ_TIMER_PAUSE_EN
  input  logic             i_Pause,
`endif
  output logic [WIDTH-1:0] o_Count,
  output logic             o_Tick,
  output logic             o_Busy,
  output logic             o_Done,
  output logic             o_Sat
);

  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam int EW  = elapsed_width(TIMEOUT_TICKS);

  localparam logic [EW-1:0]    LAST_TICK = EW'(TIMEOUT_TICKS - 1);
  localparam logic [WIDTH-1:0] COUNT_MAX = '1;
  localparam logic [WIDTH-1:0] COUNT_PRE = COUNT_MAX - WIDTH'(1);

  if (!params_ok(CLK_HZ, TICK_HZ, TIMEOUT_TICKS)) begin : g_bad_params
    $error("bj_timer_counter: CLK_HZ/TICK_HZ must be an integer >= 2 and TIMEOUT_TICKS >= 1");
  end

  timer_state_t  state;
  logic [EW-1:0] elapsed;
  logic          start_ok;
  logic          wrap;

  // Abort beats a simultaneous start in every state.
  assign start_ok = i_Start && !i_Abort;

`ifdef BJ_TIMER_PAUSE_EN
  logic hold;

  // Pause only matters while the timer is running.
  assign hold = i_Pause && (state == RUN);
`endif

  bj_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk_50M (clk_50M),
    .i_Reset (i_Reset),
    .restart (start_ok),
`ifdef BJ_TIMER_PAUSE_EN
    .hold    (hold),
`endif
    .tick    (o_Tick),
    .wrap    (wrap)
  );

  // Saturating event counter: clear beats increment, no wrap at full scale.
  always_ff @(posedge clk_50M) begin
    if (i_Reset) begin
      o_Count <= '0;
      o_Sat   <= 1'b0;
    end else if (i_Clear) begin
      o_Count <= '0;
      o_Sat   <= 1'b0;
    end else if (i_Inc && (o_Count != COUNT_MAX)) begin
      o_Count <= o_Count + WIDTH'(1);
      if (o_Count == COUNT_PRE) begin
        o_Sat <= 1'b1;
      end
    end
  end

  // Timeout FSM: counts prescaler wraps while running and pulses o_Done for
  // one cycle on the last one; the transition shares the edge that raises o_Tick.
  always_ff @(posedge clk_50M) begin
    if (i_Reset) begin
      state   <= IDLE;
      elapsed <= '0;
      o_Busy  <= 1'b0;
      o_Done  <= 1'b0;
    end else begin
      o_Done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            state   <= RUN;
            elapsed <= '0;
            o_Busy  <= 1'b1;
          end
        end
        RUN: begin
          if (i_Abort) begin
            state   <= IDLE;
            elapsed <= '0;
            o_Busy  <= 1'b0;
          end else if (i_Start) begin
            elapsed <= '0;
          end else if (wrap) begin
            if (elapsed == LAST_TICK) begin
              state   <= DONE;
              elapsed <= '0;
              o_Busy  <= 1'b0;
              o_Done  <= 1'b1;
            end else begin
              elapsed <= elapsed + EW'(1);
            end
          end
        end
        DONE: begin
          elapsed <= '0;
          if (start_ok) begin
            state  <= RUN;
            o_Busy <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          elapsed <= '0;
          o_Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/bj_timer_counter.md
Name: bj_timer_counter

Overview:
Parametrised event counter plus one-shot timeout timer for the BlackJack datapath, in a single clk_50M domain.
- An internal prescaler derives a tick strobe, replacing the separate 2 kHz clock of the previous generation.
- The FSM uses o_Count for card/score counting.
- The FSM uses o_Done for fixed display delays (default 2 s).

Parameters:
WIDTH, 12, event counter width in bits
CLK_HZ, 50000000, frequency of clk_50M in Hz
TICK_HZ, 2000, timer tick rate; DIV = CLK_HZ/TICK_HZ must be an integer >= 2
TIMEOUT_TICKS, 4000, ticks per timeout (4000 ticks at 2 kHz = 2 s); must be >= 1

Ports:
clk_50M  in  1  system clock, 50 MHz
i_Reset  in  1  synchronous active-high reset
i_Clear  in  1  synchronous clear of event counter and o_Sat
i_Inc    in  1  increment event counter by 1 (one-cycle request)
i_Start  in  1  arm/retrigger timeout timer
i_Abort  in  1  cancel timer without o_Done
o_Count  out WIDTH  event count
o_Tick   out 1  one-cycle prescaler strobe
o_Busy   out 1  timer running
o_Done   out 1  one-cycle timeout pulse
o_Sat    out 1  event counter saturated

Behaviour:
- Reset: i_Reset, synchronous, active-high; clock clk_50M.
- Reset values: o_Count=0, o_Sat=0, o_Tick=0, o_Busy=0, o_Done=0, prescaler=0, elapsed=0, state IDLE.
- All outputs are registered.
- Prescaler:
  - Counts 0..DIV-1 and wraps to 0.
  - o_Tick=1 for exactly the cycle after the prescaler holds DIV-1.
  - Free-running in all states.
  - Forced to 0 on an accepted i_Start.
- Event counter priority: i_Reset > i_Clear > i_Inc.
  - i_Inc with o_Count < 2^WIDTH-1: o_Count+1 on the next cycle.
  - At 2^WIDTH-1: o_Count holds (no wrap) and o_Sat=1 from the next cycle.
  - i_Clear: o_Count=0, o_Sat=0 next cycle; a simultaneous i_Inc is ignored.
- Timer FSM states: IDLE, RUN, DONE.
  - IDLE: i_Start -> RUN; elapsed=0, prescaler=0.
  - RUN:
    - each o_Tick increments elapsed;
    - on the tick where elapsed reaches TIMEOUT_TICKS -> DONE;
    - i_Start -> retrigger (elapsed=0, prescaler=0, remain RUN);
    - i_Abort -> IDLE.
  - DONE: lasts exactly one cycle, o_Done=1, then IDLE. An i_Start seen in DONE -> RUN (restart); o_Done still pulses.
  - i_Abort and i_Start in the same cycle: i_Abort wins.
  - i_Abort in IDLE/DONE: no effect.
- Latency: i_Start sampled at edge k -> o_Busy=1 from k+1. Then o_Done=1 in cycle k + TIMEOUT_TICKS*DIV + 1 and o_Busy=0 that same cycle.
- o_Busy=1 only in RUN; o_Done=1 only in DONE.
- Elapsed width: $clog2(TIMEOUT_TICKS+1).
- Timer and event counter are independent; i_Clear does not affect the timer.
- Reset mid-RUN: next cycle IDLE with no o_Done.

Optional Feature:
Macro BJ_TIMER_PAUSE_EN.
- Defined: adds input i_Pause (1 bit).
  - While i_Pause=1 in RUN, prescaler and elapsed hold and o_Tick=0.
  - i_Abort and i_Start still act.
  - o_Done is delayed by exactly the number of paused cycles.
- Undefined: no port, no pause logic; behaviour as above.

Decomposition:
- Package bj_timer_pkg:
  - state enum (IDLE, RUN, DONE);
  - function computing DIV and widths;
  - elaboration-time parameter checks (CLK_HZ % TICK_HZ == 0, DIV >= 2, TIMEOUT_TICKS >= 1).
- Sub-module bj_tick_gen: prescaler with restart (and pause when enabled), producing o_Tick.
- The event counter and FSM stay in the top.

Test Plan:
Use sim parameters CLK_HZ=10, TICK_HZ=2 (DIV=5), TIMEOUT_TICKS=3, WIDTH=3.
- Reset, then i_Start at edge 0 -> o_Busy=1 from cycle 1; o_Done one-cycle pulse at cycle 16; o_Busy=0 at cycle 16.
- i_Start, then i_Start again at cycle 7 -> o_Done at cycle 23, none at 16.
- i_Start, then i_Abort at cycle 8 -> no o_Done, o_Busy=0 at cycle 9; i_Abort+i_Start same cycle -> stays IDLE.
- 9 consecutive i_Inc pulses -> o_Count 1..7 then holds at 7; o_Sat=1 after the 7th; i_Clear+i_Inc -> o_Count=0, o_Sat=0.
- i_Reset asserted in RUN with o_Count=5 -> next cycle all outputs 0, no o_Done within 20 cycles.
- BJ_TIMER_PAUSE_EN: i_Start, i_Pause high cycles 4-9 (6 cycles) -> o_Done at cycle 22, o_Tick absent during pause.
